shift_n: RTL

SHIFT_N -- requirements
Module: shift_n

---
 rtl/shift_n.sv | 121 ++++++++++++
 1 files changed

// File: rtl/shift_n.sv
// ----------------------------------------------------------------------------
// shift_n -- complex-sample delay line with a valid-bit chain and a small
// IDLE/RUN/DRAIN controller.
//
// Every accepted sample comes out unmodified exactly DEPTH cycles later.
// Once input stops, the line keeps clocking in zeros until the last real
// sample has left. It then parks in IDLE with every stage cleared.
//
// Parameters
//   DW    : signed width of each real / imaginary sample
//   DEPTH : number of delay stages (1..64)
//   CNTW  : width of the accepted-sample counter
//
// Ports
//   clk       : clock, rising edge
//   reset     : synchronous active-high reset
//   in_valid  : din_r/din_i carry a sample this cycle
//   din_r     : signed real input
//   din_i     : signed imaginary input
//   dout_r    : signed real output (last stage, registered)
//   dout_i    : signed imaginary output (last stage, registered)
//   out_valid : dout holds a sample that entered with in_valid=1
//   busy      : controller is not IDLE
//   in_cnt    : accepted samples, modulo 2^CNTW
// ----------------------------------------------------------------------------
module shift_n #(
  parameter int DW    = 24,
  parameter int DEPTH = 2,
  parameter int CNTW  = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] din_r,
  input  logic signed [DW-1:0] din_i,
  output logic signed [DW-1:0] dout_r,
  output logic signed [DW-1:0] dout_i,
  output logic                 out_valid,
  output logic                 busy,
  output logic [CNTW-1:0]      in_cnt
);

  // Wide enough to hold DEPTH-1, and at least one bit when DEPTH=1.
  localparam int DCW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t               state_q;
  logic [DCW-1:0]       drain_cnt_q;
  logic [CNTW-1:0]      cnt_q;
  logic [DEPTH-1:0]     vbit_q;
  logic signed [DW-1:0] stage_r_q [DEPTH];
  logic signed [DW-1:0] stage_i_q [DEPTH];
  logic                 en;

  // The line only advances when there is input or something still in
  // flight. An idle line is all zeros, so holding it is equivalent to
  // shifting zeros.
  assign en = in_valid | (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      drain_cnt_q <= '0;
      cnt_q       <= '0;
      vbit_q      <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        stage_r_q[k] <= '0;
        stage_i_q[k] <= '0;
      end
    end else begin
      if (in_valid) cnt_q <= cnt_q + 1'b1;

      // stage 0 input / stage k-1 -> stage k boundary
      if (en) begin
        stage_r_q[0] <= in_valid ? din_r : '0;
        stage_i_q[0] <= in_valid ? din_i : '0;
        vbit_q[0]    <= in_valid;
        for (int k = 1; k < DEPTH; k++) begin
          stage_r_q[k] <= stage_r_q[k-1];
          stage_i_q[k] <= stage_i_q[k-1];
          vbit_q[k]    <= vbit_q[k-1];
        end
      end

      // The RUN exit shifts one zero and DRAIN shifts DEPTH-1 more. That
      // makes exactly DEPTH zero-shifts, which flushes every stage.
      case (state_q)
        IDLE: begin
          if (in_valid) state_q <= RUN;
        end
        RUN: begin
          if (!in_valid) begin
            if (DEPTH == 1) begin
              state_q <= IDLE;
            end else begin
              state_q     <= DRAIN;
              drain_cnt_q <= DCW'(DEPTH - 1);
            end
          end
        end
        DRAIN: begin
          if (in_valid) begin
            state_q <= RUN;
          end else begin
            drain_cnt_q <= drain_cnt_q - 1'b1;
            if (drain_cnt_q == DCW'(1)) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dout_r    = stage_r_q[DEPTH-1];
  assign dout_i    = stage_i_q[DEPTH-1];
  assign out_valid = vbit_q[DEPTH-1];
  assign busy      = (state_q != IDLE);
  assign in_cnt    = cnt_q;

endmodule
